// File: rtl/meu_dmux8way16_reg_pkg.sv
// Shared constants for the 8-way 16-bit registered demultiplexer.
// Optional per-channel delivery counters are enabled with DMUX8_CONTADORES_EN.
package meu_pkg_canais;

    localparam int unsigned LARGURA_PADRAO   = 16;
    localparam int unsigned LARGURA_CONTADOR = 8;
    localparam int unsigned NUM_CANAIS       = 8;
    localparam int unsigned LARGURA_SEL      = 3;

    localparam logic [LARGURA_SEL-1:0] CANAL_A = 3'd0;
    localparam logic [LARGURA_SEL-1:0] CANAL_B = 3'd1;
    localparam logic [LARGURA_SEL-1:0] CANAL_C = 3'd2;
    localparam logic [LARGURA_SEL-1:0] CANAL_D = 3'd3;
    localparam logic [LARGURA_SEL-1:0] CANAL_E = 3'd4;
    localparam logic [LARGURA_SEL-1:0] CANAL_F = 3'd5;
    localparam logic [LARGURA_SEL-1:0] CANAL_G = 3'd6;
    localparam logic [LARGURA_SEL-1:0] CANAL_H = 3'd7;

    // One-hot decode of a channel index.
    function automatic logic [NUM_CANAIS-1:0] decodifica_canal(input logic [LARGURA_SEL-1:0] sel);
        return NUM_CANAIS'(1) << sel;
    endfunction

endpackage

// File: rtl/meu_dmux8way16_reg_canal.sv
// One-entry valid/ready holding register for a single demux channel.
// With DMUX8_CONTADORES_EN defined it also counts completed deliveries.
module meu_registro_canal
    import meu_pkg_canais::*;
#(
    parameter int unsigned LARGURA = LARGURA_PADRAO
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_carga,
    input  logic [LARGURA-1:0]          i_dados,
    input  logic                        i_pronta,
`ifdef DMUX8_CONTADORES_EN
    output logic [LARGURA_CONTADOR-1:0] o_contador,
`endif
    output logic [LARGURA-1:0]          o_dados,
    output logic                        o_valida,
    output logic                        o_livre_c
);

    logic [LARGURA-1:0] r_dados;
    logic               r_valida;
    logic               w_drena;

    // A word leaves when the consumer takes it; the slot is free if empty or leaving.
    assign w_drena   = r_valida & i_pronta;
    assign o_livre_c = ~r_valida | i_pronta;
    assign o_dados   = r_dados;
    assign o_valida  = r_valida;

    // Holding register: load wins over drain so a same-cycle refill keeps valid high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dados  <= '0;
            r_valida <= 1'b0;
        end else if (i_carga) begin
            r_dados  <= i_dados;
            r_valida <= 1'b1;
        end else if (w_drena) begin
            r_valida <= 1'b0;
        end
    end

`ifdef DMUX8_CONTADORES_EN
    logic [LARGURA_CONTADOR-1:0] r_contador;

    assign o_contador = r_contador;

    // Delivery counter, wraps naturally at its width.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_contador <= '0;
        end else if (w_drena) begin
            r_contador <= r_contador + LARGURA_CONTADOR'(1);
        end
    end
`endif

endmodule

// File: rtl/meu_dmux8way16_reg.sv
// Registered 1-to-8 demultiplexer: routes each accepted word to the channel
// chosen by seletor_ctrl. Optional macro: DMUX8_CONTADORES_EN (delivery counters).
module meu_dmux8way16_reg
    import meu_pkg_canais::*;
#(
    parameter int unsigned LARGURA = LARGURA_PADRAO
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [LARGURA-1:0]      entrada_dados,
    input  logic                    entrada_valida,
    output logic                    entrada_pronta,
    input  logic [LARGURA_SEL-1:0]  seletor_ctrl,
    output logic [LARGURA-1:0]      saida_a,
    output logic [LARGURA-1:0]      saida_b,
    output logic [LARGURA-1:0]      saida_c,
    output logic [LARGURA-1:0]      saida_d,
    output logic [LARGURA-1:0]      saida_e,
    output logic [LARGURA-1:0]      saida_f,
    output logic [LARGURA-1:0]      saida_g,
    output logic [LARGURA-1:0]      saida_h,
    output logic [NUM_CANAIS-1:0]   saida_valida,
`ifdef DMUX8_CONTADORES_EN
    output logic [NUM_CANAIS*LARGURA_CONTADOR-1:0] contador_entregas,
`endif
    input  logic [NUM_CANAIS-1:0]   saida_pronta
);

    logic [NUM_CANAIS-1:0] w_sel_oh;
    logic [NUM_CANAIS-1:0] w_livre;
    logic [NUM_CANAIS-1:0] w_carga;
    logic                  w_aceita;
    logic [LARGURA-1:0]    w_dados [NUM_CANAIS];

    // Ready reflects only the currently selected channel; independent of entrada_valida.
    assign w_sel_oh       = decodifica_canal(seletor_ctrl);
    assign entrada_pronta = w_livre[seletor_ctrl];
    assign w_aceita       = entrada_valida & entrada_pronta;
    assign w_carga        = {NUM_CANAIS{w_aceita}} & w_sel_oh;

    for (genvar g = 0; g < NUM_CANAIS; g++) begin : g_canal
        meu_registro_canal #(
            .LARGURA    (LARGURA)
        ) u_canal (
            .clk        (clk),
            .reset      (reset),
            .i_carga    (w_carga[g]),
            .i_dados    (entrada_dados),
            .i_pronta   (saida_pronta[g]),
`ifdef DMUX8_CONTADORES_EN
            .o_contador (contador_entregas[g*LARGURA_CONTADOR +: LARGURA_CONTADOR]),
`endif
            .o_dados    (w_dados[g]),
            .o_valida   (saida_valida[g]),
            .o_livre_c  (w_livre[g])
        );
    end

    assign saida_a = w_dados[CANAL_A];
    assign saida_b = w_dados[CANAL_B];
    assign saida_c = w_dados[CANAL_C];
    assign saida_d = w_dados[CANAL_D];
    assign saida_e = w_dados[CANAL_E];
    assign saida_f = w_dados[CANAL_F];
    assign saida_g = w_dados[CANAL_G];
    assign saida_h = w_dados[CANAL_H];

endmodule

// File: tb/tb_meu_dmux8way16_reg.sv
// Self-checking bench for meu_dmux8way16_reg: directed vector table,
// counter wrap sequence (DMUX8_CONTADORES_EN) and randomized traffic vs a model.
module tb_meu_dmux8way16_reg;
    import meu_pkg_canais::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] entrada_dados = '0;
    logic        entrada_valida = 1'b0;
    logic        entrada_pronta;
    logic [2:0]  seletor_ctrl = '0;
    logic [15:0] saida_a, saida_b, saida_c, saida_d;
    logic [15:0] saida_e, saida_f, saida_g, saida_h;
    logic [7:0]  saida_valida;
    logic [7:0]  saida_pronta = '0;
`ifdef DMUX8_CONTADORES_EN
    logic [63:0] contador_entregas;
`endif

    always #5 clk = ~clk;

    meu_dmux8way16_reg #(.LARGURA(16)) dut (
        .clk               (clk),
        .reset             (reset),
        .entrada_dados     (entrada_dados),
        .entrada_valida    (entrada_valida),
        .entrada_pronta    (entrada_pronta),
        .seletor_ctrl      (seletor_ctrl),
        .saida_a           (saida_a),
        .saida_b           (saida_b),
        .saida_c           (saida_c),
        .saida_d           (saida_d),
        .saida_e           (saida_e),
        .saida_f           (saida_f),
        .saida_g           (saida_g),
        .saida_h           (saida_h),
        .saida_valida      (saida_valida),
`ifdef DMUX8_CONTADORES_EN
        .contador_entregas (contador_entregas),
`endif
        .saida_pronta      (saida_pronta)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: occupancy count per channel (0 or 1), last word loaded, deliveries.
    int          occ    [8];
    logic [15:0] last_w [8];
    int          cnt    [8];

    typedef struct {
        logic        rst;
        logic        vld;
        logic [2:0]  sel;
        logic [15:0] d;
        logic [7:0]  rdy;
        logic        chk_pronta;
        logic        exp_pronta;
        logic [7:0]  exp_valid;
        logic [2:0]  chk_ch;
        logic [15:0] exp_word;
    } vec_t;

    vec_t tbl [19];

    function automatic logic [15:0] saida_de(input int ch);
        case (ch)
            0: return saida_a;
            1: return saida_b;
            2: return saida_c;
            3: return saida_d;
            4: return saida_e;
            5: return saida_f;
            6: return saida_g;
            default: return saida_h;
        endcase
    endfunction

    function automatic logic [127:0] todas_saidas();
        return {saida_h, saida_g, saida_f, saida_e, saida_d, saida_c, saida_b, saida_a};
    endfunction

    function automatic logic [7:0] mdl_valid();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = (occ[i] != 0);
        return v;
    endfunction

    function automatic logic [127:0] mdl_saidas();
        logic [127:0] v;
        for (int i = 0; i < 8; i++) v[i*16 +: 16] = last_w[i];
        return v;
    endfunction

    function automatic logic [63:0] mdl_cont();
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[i*8 +: 8] = 8'(cnt[i]);
        return v;
    endfunction

    task automatic chk(input string nome, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nome, got, exp, $time);
        end
    endtask

    // One clock: drive at negedge, sample ready, advance model on the edge, settle.
    task automatic ciclo(input logic rst, input logic vld, input logic [2:0] sel,
                         input logic [15:0] d, input logic [7:0] rdy,
                         output logic obs_pronta, output logic exp_pronta);
        @(negedge clk);
        reset          = rst;
        entrada_valida = vld;
        seletor_ctrl   = sel;
        entrada_dados  = d;
        saida_pronta   = rdy;
        #1;
        obs_pronta = entrada_pronta;
        exp_pronta = (occ[sel] == 0) || rdy[sel];
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                occ[i] = 0; last_w[i] = '0; cnt[i] = 0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (occ[i] > 0 && rdy[i]) begin
                    occ[i] = occ[i] - 1;
                    cnt[i] = (cnt[i] + 1) % 256;
                end
            end
            if (vld && exp_pronta) begin
                occ[sel]    = occ[sel] + 1;
                last_w[sel] = d;
            end
        end
        #1;
    endtask

    initial begin
        logic op, mp;
        for (int i = 0; i < 8; i++) begin
            occ[i] = 0; last_w[i] = '0; cnt[i] = 0;
        end

        //          rst   vld   sel   d         rdy    chkp  expp  valid  ch    word
        tbl[0]  = '{1'b1, 1'b0, 3'd0, 16'h0000, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 16'h0000};
        tbl[1]  = '{1'b1, 1'b0, 3'd5, 16'h0000, 8'h00, 1'b1, 1'b1, 8'h00, 3'd5, 16'h0000};
        tbl[2]  = '{1'b0, 1'b0, 3'd0, 16'h0000, 8'h00, 1'b1, 1'b1, 8'h00, 3'd7, 16'h0000};
        tbl[3]  = '{1'b0, 1'b1, 3'd5, 16'hBEEF, 8'h00, 1'b1, 1'b1, 8'h20, 3'd5, 16'hBEEF};
        tbl[4]  = '{1'b0, 1'b1, 3'd5, 16'h1111, 8'h00, 1'b1, 1'b0, 8'h20, 3'd5, 16'hBEEF};
        tbl[5]  = '{1'b0, 1'b0, 3'd5, 16'h0000, 8'h20, 1'b1, 1'b1, 8'h00, 3'd5, 16'hBEEF};
        tbl[6]  = '{1'b0, 1'b1, 3'd2, 16'h0001, 8'hFF, 1'b1, 1'b1, 8'h04, 3'd2, 16'h0001};
        tbl[7]  = '{1'b0, 1'b1, 3'd2, 16'h0002, 8'hFF, 1'b1, 1'b1, 8'h04, 3'd2, 16'h0002};
        tbl[8]  = '{1'b0, 1'b1, 3'd2, 16'h0003, 8'hFF, 1'b1, 1'b1, 8'h04, 3'd2, 16'h0003};
        tbl[9]  = '{1'b0, 1'b1, 3'd2, 16'h0004, 8'hFF, 1'b1, 1'b1, 8'h04, 3'd2, 16'h0004};
        tbl[10] = '{1'b0, 1'b0, 3'd2, 16'h0000, 8'hFF, 1'b1, 1'b1, 8'h00, 3'd2, 16'h0004};
        tbl[11] = '{1'b0, 1'b1, 3'd0, 16'hAAAA, 8'h00, 1'b1, 1'b1, 8'h01, 3'd0, 16'hAAAA};
        tbl[12] = '{1'b0, 1'b1, 3'd0, 16'h5555, 8'h00, 1'b1, 1'b0, 8'h01, 3'd0, 16'hAAAA};
        tbl[13] = '{1'b0, 1'b1, 3'd7, 16'h1234, 8'h00, 1'b1, 1'b1, 8'h81, 3'd7, 16'h1234};
        tbl[14] = '{1'b0, 1'b0, 3'd0, 16'h0000, 8'h00, 1'b1, 1'b0, 8'h81, 3'd0, 16'hAAAA};
        tbl[15] = '{1'b0, 1'b1, 3'd1, 16'h0B0B, 8'h80, 1'b1, 1'b1, 8'h03, 3'd1, 16'h0B0B};
        tbl[16] = '{1'b0, 1'b1, 3'd3, 16'h0D0D, 8'h00, 1'b1, 1'b1, 8'h0B, 3'd3, 16'h0D0D};
        tbl[17] = '{1'b1, 1'b1, 3'd4, 16'h4444, 8'h00, 1'b1, 1'b1, 8'h00, 3'd3, 16'h0000};
        tbl[18] = '{1'b0, 1'b0, 3'd4, 16'h0000, 8'h00, 1'b1, 1'b1, 8'h00, 3'd4, 16'h0000};

        // Directed vectors
        for (int k = 0; k < 19; k++) begin
            ciclo(tbl[k].rst, tbl[k].vld, tbl[k].sel, tbl[k].d, tbl[k].rdy, op, mp);
            if (tbl[k].chk_pronta) chk($sformatf("tbl%0d_pronta", k), 128'(op), 128'(tbl[k].exp_pronta));
            chk($sformatf("tbl%0d_valida", k), 128'(saida_valida), 128'(tbl[k].exp_valid));
            chk($sformatf("tbl%0d_dados", k), 128'(saida_de(int'(tbl[k].chk_ch))), 128'(tbl[k].exp_word));
        end
        chk("reset_all_data", todas_saidas(), 128'h0);

`ifdef DMUX8_CONTADORES_EN
        // Counter wrap on channel g: 255 deliveries during streaming, one more after
        ciclo(1'b1, 1'b0, 3'd0, 16'h0, 8'h00, op, mp);
        chk("cont_reset", 128'(contador_entregas), 128'h0);
        for (int k = 0; k < 256; k++) ciclo(1'b0, 1'b1, 3'd6, 16'(k), 8'h40, op, mp);
        chk("cont_g_255", 128'(contador_entregas), 128'(64'h00FF_0000_0000_0000));
        chk("stream_g_data", 128'(saida_g), 128'(16'h00FF));
        ciclo(1'b0, 1'b0, 3'd6, 16'h0, 8'h40, op, mp);
        chk("cont_g_wrap", 128'(contador_entregas), 128'h0);
`endif

        // Randomized traffic against the model
        for (int k = 0; k < 800; k++) begin
            logic        r_rst;
            logic        r_vld;
            logic [2:0]  r_sel;
            logic [15:0] r_d;
            logic [7:0]  r_rdy;
            r_rst = ($urandom_range(0, 59) == 0);
            r_vld = ($urandom_range(0, 3) != 0);
            r_sel = 3'($urandom_range(0, 7));
            r_d   = 16'($urandom);
            r_rdy = 8'($urandom);
            ciclo(r_rst, r_vld, r_sel, r_d, r_rdy, op, mp);
            if (!r_rst) chk("rnd_pronta", 128'(op), 128'(mp));
            chk("rnd_valida", 128'(saida_valida), 128'(mdl_valid()));
            chk("rnd_dados", todas_saidas(), mdl_saidas());
`ifdef DMUX8_CONTADORES_EN
            chk("rnd_cont", 128'(contador_entregas), 128'(mdl_cont()));
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
